// File: rtl/sync_updown_counter_if.sv
// Bus bundle for sync_updown_counter: the control/load inputs and the count/status outputs.
//   en, up, load, load_val : driven by the master (user logic)
//   count, tc, wrap, sat   : driven by the counter (slave)
interface sync_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             sat;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrap, sat
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrap, sat
    );
endinterface

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with modulus, load, enable prescaler and
// wrap-or-saturate boundary behaviour.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus.en       count enable (feeds the prescaler)
//   bus.up       direction, 1 = increment
//   bus.load     synchronous load, wins over a step
//   bus.load_val load value, clamped to MODULUS-1
//   bus.count    registered count, always in 0..MODULUS-1
//   bus.tc       combinational terminal count (step about to hit a boundary)
//   bus.wrap     registered one-cycle pulse after a boundary wrap
//   bus.sat      registered level while held at a boundary (SATURATE=1)
module sync_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_updown_counter_if.slave  bus
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX      = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;

    logic             step;
    logic             at_bound;
    logic             load_at_bound;
    logic [WIDTH-1:0] load_clamped;

    // Next-state: load beats step beats hold
    always_comb begin
        step          = bus.en && (pre_q == PRE_LAST);
        at_bound      = bus.up ? (count_q == MAX) : (count_q == '0);
        load_clamped  = (bus.load_val > MAX) ? MAX : bus.load_val;
        load_at_bound = bus.up ? (load_clamped == MAX) : (load_clamped == '0);

        count_d = count_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;
        // A held level survives only while the direction still points into its boundary
        sat_d   = sat_q && at_bound;

        if (bus.load) begin
            count_d = load_clamped;
            pre_d   = '0;
            sat_d   = (SATURATE != 0) && load_at_bound;
        end else if (step) begin
            pre_d = '0;
            if (at_bound) begin
                if (SATURATE != 0) begin
                    sat_d = 1'b1;
                end else begin
                    count_d = bus.up ? '0 : MAX;
                    wrap_d  = 1'b1;
                end
            end else begin
                // Not at a boundary, so +/-1 cannot leave 0..MAX
                count_d = bus.up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
                sat_d   = 1'b0;
            end
        end else if (bus.en) begin
            pre_d = pre_q + PW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    // tc is gated by rst so every output reads 0 while reset is held
    assign bus.tc    = rst && step && at_bound;
    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.sat   = sat_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Randomised bench for sync_updown_counter: three parameterisations share one stimulus
// stream and are compared every cycle against an arithmetic model of the counter rules.
module tb_sync_updown_counter;

    localparam int NI = 3;
    // instance 0: default; 1: modulus 10 with prescale 3; 2: modulus 10 saturating
    localparam int MODV[NI] = '{16, 10, 10};
    localparam int SATV[NI] = '{0, 0, 1};
    localparam int PREV[NI] = '{1, 3, 1};

    logic clk = 1'b0;
    logic rst;
    logic en, up, load;
    logic [3:0] lv;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // model state
    int mc[NI];
    int mp[NI];
    int mw[NI];
    int ms[NI];

    always #5 clk = ~clk;

    sync_updown_counter_if #(.WIDTH(4)) ia ();
    sync_updown_counter_if #(.WIDTH(4)) ib ();
    sync_updown_counter_if #(.WIDTH(4)) ic ();

    assign ia.en = en;  assign ia.up = up;  assign ia.load = load;  assign ia.load_val = lv;
    assign ib.en = en;  assign ib.up = up;  assign ib.load = load;  assign ib.load_val = lv;
    assign ic.en = en;  assign ic.up = up;  assign ic.load = load;  assign ic.load_val = lv;

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) dut_c (
        .clk(clk), .rst(rst), .bus(ic.slave));

    task automatic cmp(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mc[i] = 0; mp[i] = 0; mw[i] = 0; ms[i] = 0;
        end
    endtask

    function automatic int boundary(input int i, input int c);
        return up ? int'(c == MODV[i] - 1) : int'(c == 0);
    endfunction

    function automatic int model_tc(input int i);
        return int'(rst && en && (mp[i] == PREV[i] - 1)) & boundary(i, mc[i]);
    endfunction

    // One rising edge of the counter rules, applied with the inputs now on the pins
    task automatic model_edge();
        int mx, v, stp;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                mx  = MODV[i] - 1;
                stp = int'(en && (mp[i] == PREV[i] - 1));
                if (load) begin
                    v     = (int'(lv) > mx) ? mx : int'(lv);
                    mc[i] = v;
                    mp[i] = 0;
                    mw[i] = 0;
                    ms[i] = SATV[i] & boundary(i, v);
                end else if (stp != 0) begin
                    mp[i] = 0;
                    if (boundary(i, mc[i]) != 0) begin
                        if (SATV[i] != 0) begin
                            ms[i] = 1; mw[i] = 0;
                        end else begin
                            mc[i] = up ? 0 : mx; mw[i] = 1; ms[i] = 0;
                        end
                    end else begin
                        mc[i] = (mc[i] + (up ? 1 : MODV[i] - 1)) % MODV[i];
                        mw[i] = 0; ms[i] = 0;
                    end
                end else begin
                    if (en) mp[i] = mp[i] + 1;
                    mw[i] = 0;
                    ms[i] = ms[i] & boundary(i, mc[i]);
                end
            end
        end
    endtask

    task automatic tick(input bit e, input bit u, input bit l, input int v);
        en = e; up = u; load = l; lv = 4'(v);
        @(negedge clk);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("a_count", int'(ia.count), mc[0]);
            cmp("a_wrap",  int'(ia.wrap),  mw[0]);
            cmp("a_sat",   int'(ia.sat),   ms[0]);
            cmp("a_tc",    int'(ia.tc),    model_tc(0));
            cmp("b_count", int'(ib.count), mc[1]);
            cmp("b_wrap",  int'(ib.wrap),  mw[1]);
            cmp("b_sat",   int'(ib.sat),   ms[1]);
            cmp("b_tc",    int'(ib.tc),    model_tc(1));
            cmp("c_count", int'(ic.count), mc[2]);
            cmp("c_wrap",  int'(ic.wrap),  mw[2]);
            cmp("c_sat",   int'(ic.sat),   ms[2]);
            cmp("c_tc",    int'(ic.tc),    model_tc(2));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit u;
        rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; lv = 4'd0;
        model_reset();
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        // tc must stay low in reset even though a step condition exists
        en = 1'b1;
        #1;
        cmp("lit_a_tc_in_reset", int'(ia.tc), 0);
        cmp("lit_a_count_reset", int'(ia.count), 0);
        @(posedge clk);
        #1;

        // release between edges, count down through zero
        rst = 1'b1;
        en = 1'b1; up = 1'b0; load = 1'b0;
        #1;
        cmp("lit_a_tc_at_zero", int'(ia.tc), 1);
        cmp("lit_b_tc_prescaled", int'(ib.tc), 0);
        cmp("lit_c_tc_at_zero", int'(ic.tc), 1);
        tick(1, 0, 0, 0);
        cmp("lit_a_wrap_to_15", int'(ia.count), 15);
        cmp("lit_a_wrap_pulse", int'(ia.wrap), 1);
        cmp("lit_c_hold_zero", int'(ic.count), 0);
        cmp("lit_c_sat_zero", int'(ic.sat), 1);
        cmp("lit_c_no_wrap", int'(ic.wrap), 0);
        tick(1, 0, 0, 0);
        cmp("lit_a_count_14", int'(ia.count), 14);
        cmp("lit_a_wrap_clears", int'(ia.wrap), 0);
        tick(1, 0, 0, 0);
        cmp("lit_b_wrap_to_9", int'(ib.count), 9);
        cmp("lit_b_wrap_pulse", int'(ib.wrap), 1);

        // load priority and clamping
        tick(1, 1, 1, 12);
        cmp("lit_a_load_12", int'(ia.count), 12);
        cmp("lit_c_load_clamp", int'(ic.count), 9);
        cmp("lit_c_load_sat", int'(ic.sat), 1);
        cmp("lit_b_load_clamp", int'(ib.count), 9);
        tick(1, 1, 1, 3);
        cmp("lit_c_load_3", int'(ic.count), 3);
        cmp("lit_c_load_unsat", int'(ic.sat), 0);

        // prescaler phase, held across en=0
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        cmp("lit_b_prescale_wait", int'(ib.count), 3);
        tick(0, 1, 0, 0);
        cmp("lit_b_en_low_hold", int'(ib.count), 3);
        tick(1, 1, 0, 0);
        cmp("lit_b_prescale_step", int'(ib.count), 4);

        // saturation at MAX, then released by direction change
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        cmp("lit_c_reach_9", int'(ic.count), 9);
        cmp("lit_c_not_yet_sat", int'(ic.sat), 0);
        tick(1, 1, 0, 0);
        cmp("lit_c_held_9", int'(ic.count), 9);
        cmp("lit_c_sat_9", int'(ic.sat), 1);
        tick(1, 0, 0, 0);
        cmp("lit_c_down_8", int'(ic.count), 8);
        cmp("lit_c_unsat_8", int'(ic.sat), 0);

        // asynchronous reset while a wrap pulse and a sat level are showing
        tick(1, 1, 1, 15);
        tick(1, 1, 0, 0);
        cmp("lit_a_wrap_before_rst", int'(ia.wrap), 1);
        cmp("lit_c_sat_before_rst", int'(ic.sat), 1);
        cmp("lit_b_count_before_rst", int'(ib.count), 9);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        cmp("lit_a_wrap_async_rst", int'(ia.wrap), 0);
        cmp("lit_c_sat_async_rst", int'(ic.sat), 0);
        cmp("lit_b_count_async_rst", int'(ib.count), 0);
        cmp("lit_c_count_async_rst", int'(ic.count), 0);
        tick(1, 1, 0, 0);
        rst = 1'b1;
        tick(1, 1, 0, 0);
        cmp("lit_a_resume_1", int'(ia.count), 1);
        tick(1, 1, 0, 0);
        cmp("lit_b_full_period", int'(ib.count), 0);
        tick(1, 1, 0, 0);
        cmp("lit_b_first_step", int'(ib.count), 1);

        // randomised run
        u = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) u = ~u;
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b0;
                model_reset();
                tick(1'($urandom_range(0, 1)), u, 1'($urandom_range(0, 1)), 5);
                rst = 1'b1;
            end
            tick(($urandom_range(0, 3) != 0), u, ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, 15)));
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
